clk_edge_monitor: RTL and testbench
===================================

Name: clk_edge_monitor

Overview:
Consumer side of the divided display clock. Takes a slow clock such as CLOCK_1_HZ, or any externally generated toggle signal, and synchronises it into the main_clock domain. Emits single-cycle rise/fall strobes for display logic, measures the half-period in main_clock cycles, and flags a lost or off-frequency slow clock. Display and VGA logic use these strobes as clock enables instead of clocking registers from the slow clock.

Parameters:
SYNC_STAGES, 2, flip-flops in the input synchroniser (min 2)
CNT_W, 24, width of the half-period counter and measurement
TIMEOUT, 2_000_000, main_clock cycles without an edge before clock_lost is declared
EXPECT_HALF, 1_000_000, nominal half-period in main_clock cycles
TOL, 1_000, allowed absolute deviation from EXPECT_HALF

Ports:
main_clock  input  1  system clock; all logic on its rising edge
reset_n  input  1  asynchronous, active-low reset
slow_clock_in  input  1  asynchronous slow clock to monitor
rise_pulse  output  1  one-cycle strobe per synchronised rising edge
fall_pulse  output  1  one-cycle strobe per synchronised falling edge
half_period  output  CNT_W  main_clock cycles between the last two edges
period_valid  output  1  half_period holds a genuine edge-to-edge measurement
in_tolerance  output  1  period_valid and abs(half_period - EXPECT_HALF) <= TOL
clock_lost  output  1  no edge for TIMEOUT cycles
edge_count  output  16  count of both edge types; wraps at 16'hFFFF -> 0

Behaviour:
- Interface: one clock, main_clock; reset_n asynchronous, active-low. All flops clear immediately on reset_n low.
- Reset values: all outputs 0; synchroniser, delayed copy, counter and prime counter 0; state ACQUIRE.
- Priming: edge detection is suppressed for SYNC_STAGES+1 cycles after reset release. The delayed copy tracks the synchroniser during priming. An input held high through reset therefore produces no rise_pulse.
- Edge detect: edge = sync_last XOR delayed. Strobes are registered.
- Strobe latency: a level change first sampled at main_clock edge k gives a strobe high during cycle k+SYNC_STAGES+1, for exactly one cycle.
- Counter: an edge cycle sets cnt <= 0; otherwise cnt <= cnt+1, saturating at all-ones.
- Measurement: on an edge accepted in MEASURE or LOCKED, half_period <= cnt+1, truncated to CNT_W. For an input toggling every N cycles, half_period = N.
- in_tolerance: registered in the same cycle as half_period. Uses a signed difference one bit wider than CNT_W. Forced to 0 whenever period_valid = 0.
- State machine:
  ACQUIRE: no edge since reset or loss. On edge -> MEASURE; half_period is not updated.
  MEASURE: one edge seen. On edge -> LOCKED; half_period updated; period_valid <= 1.
  LOCKED: each edge updates half_period. Timeout -> LOST.
  LOST: clock_lost = 1; period_valid <= 0; in_tolerance <= 0; half_period holds its last value. On edge -> MEASURE; clock_lost <= 0 on that same cycle.
- Timeout: when cnt == TIMEOUT-1 with no edge in that cycle, the block enters LOST on the next edge of main_clock, from any state except LOST. ACQUIRE and MEASURE also time out.
- Simultaneous edge and timeout in the same cycle: the edge wins and no timeout is raised.
- edge_count increments on every accepted edge, in all states, including LOST->MEASURE.
- Reset mid-operation: immediate return to reset values; priming repeats.

Decomposition:
- Package clk_mon_pkg:
  - state enum ACQUIRE/MEASURE/LOCKED/LOST (2-bit encoding)
  - default constants for CNT_W, TIMEOUT, EXPECT_HALF, TOL, SYNC_STAGES
- Sub-module sync_edge_detect, parameterised by SYNC_STAGES:
  - synchroniser chain, priming counter, delayed copy
  - registered rise/fall/edge strobes
- The top level holds the counter, FSM, measurement and tolerance logic.

Test Plan:
(Bench parameters: SYNC_STAGES=2, CNT_W=8, TIMEOUT=100, EXPECT_HALF=20, TOL=2.)
1. Hold slow_clock_in=1 through reset and 10 cycles after release -> no rise_pulse; edge_count=0; state ACQUIRE; all outputs 0.
2. Toggle the input every 20 cycles -> strobe 3 cycles after each toggle. After the 2nd edge: half_period=20, period_valid=1, in_tolerance=1. After 6 edges: edge_count=6.
3. Toggle every 23 cycles -> half_period=23, period_valid=1, in_tolerance=0. Toggle every 18 cycles -> in_tolerance=1.
4. Lock at 20 cycles, then hold the input -> clock_lost=1 exactly 100 cycles after the last strobe; period_valid=0; half_period stays 20. Next toggle -> clock_lost=0, state MEASURE. Following toggle -> period_valid=1.
5. Arrange an edge on the cycle where cnt==99 -> no clock_lost; half_period=100.
6. Assert reset_n low while LOCKED with edge_count=5 -> all outputs 0 immediately, with no clock edge. Toggling after release -> MEASURE then LOCKED as in scenario 2.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared state encoding and default parameters for the slow-clock monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } mon_state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 24;
    localparam int DEF_TIMEOUT     = 2_000_000;
    localparam int DEF_EXPECT_HALF = 1_000_000;
    localparam int DEF_TOL         = 1_000;

endpackage

// File: rtl/clk_edge_monitor_sync.sv
// sync_edge_detect: synchronises an asynchronous level and emits registered rise/fall/edge strobes.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic main_clock,
    input  logic reset_n,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o,
    output logic edge_o
);

    localparam int PRIME = SYNC_STAGES + 1;
    localparam int PW    = $clog2(PRIME + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delayed_q;
    logic [PW-1:0]          prime_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   sync_last;
    logic                   primed;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign primed    = prime_q == PW'(PRIME);

    // delayed_q follows the chain even while priming, so a level held through reset is never seen as an edge
    always_ff @(posedge main_clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            delayed_q <= 1'b0;
            prime_q   <= '0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], async_i};
            delayed_q <= sync_last;
            prime_q   <= primed ? prime_q : prime_q + 1'b1;
            rise_q    <= primed & sync_last & ~delayed_q;
            fall_q    <= primed & ~sync_last & delayed_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign edge_o = rise_q | fall_q;

endmodule

// File: rtl/clk_edge_monitor.sv
// clk_edge_monitor: turns a slow asynchronous clock into main_clock strobes and
// measures its half-period, flagging loss or off-frequency operation.
module clk_edge_monitor
    import clk_mon_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int EXPECT_HALF = DEF_EXPECT_HALF,
    parameter int TOL         = DEF_TOL
) (
    input  logic             main_clock,
    input  logic             reset_n,
    input  logic             slow_clock_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             in_tolerance,
    output logic             clock_lost,
    output logic [15:0]      edge_count
);

    localparam int                W       = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]   EXP     = W'(EXPECT_HALF);
    localparam logic [CNT_W:0]   TOL_W   = W'(TOL);

    mon_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  half_q, half_d;
    logic              valid_q, valid_d;
    logic              tol_q, tol_d;
    logic [15:0]       ecnt_q, ecnt_d;
    logic              edge_s;
    logic [CNT_W-1:0]  meas;
    logic signed [CNT_W:0] diff;
    logic [CNT_W:0]    mag;
    logic              in_tol;
    logic              timeout;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .main_clock(main_clock),
        .reset_n   (reset_n),
        .async_i   (slow_clock_in),
        .rise_o    (rise_pulse),
        .fall_o    (fall_pulse),
        .edge_o    (edge_s)
    );

    // cnt counts from zero after an edge, so the interval is cnt+1
    assign meas    = cnt_q + 1'b1;
    assign diff    = $signed({1'b0, meas}) - $signed(EXP);
    assign mag     = diff < 0 ? -diff : diff;
    assign in_tol  = mag <= TOL_W;
    assign timeout = !edge_s && cnt_q == TMO && state_q != LOST;

    always_comb begin
        state_d = state_q;
        cnt_d   = edge_s ? '0 : (cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1);
        half_d  = half_q;
        valid_d = valid_q;
        tol_d   = tol_q;
        ecnt_d  = edge_s ? ecnt_q + 16'd1 : ecnt_q;
        if (edge_s) begin
            case (state_q)
                ACQUIRE: state_d = MEASURE;
                MEASURE: begin
                    state_d = LOCKED;
                    half_d  = meas;
                    valid_d = 1'b1;
                    tol_d   = in_tol;
                end
                LOCKED: begin
                    half_d = meas;
                    tol_d  = in_tol;
                end
                default: state_d = MEASURE;
            endcase
        end else if (timeout) begin
            state_d = LOST;
            valid_d = 1'b0;
            tol_d   = 1'b0;
        end
    end

    always_ff @(posedge main_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ACQUIRE;
            cnt_q   <= '0;
            half_q  <= '0;
            valid_q <= 1'b0;
            tol_q   <= 1'b0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            valid_q <= valid_d;
            tol_q   <= tol_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign half_period  = half_q;
    assign period_valid = valid_q;
    assign in_tolerance = tol_q;
    assign clock_lost   = state_q == LOST;
    assign edge_count   = ecnt_q;

endmodule

// File: tb/tb_clk_edge_monitor.sv
// tb_clk_edge_monitor: directed scenarios for clk_edge_monitor with hand-computed expectations.
module tb_clk_edge_monitor;
    import clk_mon_pkg::*;

    logic        main_clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        slow_clock_in = 1'b0;
    logic        rise_pulse;
    logic        fall_pulse;
    logic [7:0]  half_period;
    logic        period_valid;
    logic        in_tolerance;
    logic        clock_lost;
    logic [15:0] edge_count;
    logic [28:0] outs;
    int          checks = 0;
    int          failures = 0;

    clk_edge_monitor #(
        .SYNC_STAGES(2), .CNT_W(8), .TIMEOUT(100), .EXPECT_HALF(20), .TOL(2)
    ) dut (
        .main_clock   (main_clock),
        .reset_n      (reset_n),
        .slow_clock_in(slow_clock_in),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .half_period  (half_period),
        .period_valid (period_valid),
        .in_tolerance (in_tolerance),
        .clock_lost   (clock_lost),
        .edge_count   (edge_count)
    );

    assign outs = {rise_pulse, fall_pulse, half_period, period_valid, in_tolerance, clock_lost, edge_count};

    always #5 main_clock = ~main_clock;

    // wait until n cycles after the previous toggle, toggle, then settle 4 cycles so the measurement is visible
    task automatic tog_gap(input int n);
        repeat (n - 4) @(negedge main_clock);
        slow_clock_in = ~slow_clock_in;
        repeat (4) @(negedge main_clock);
    endtask

    task automatic test_reset();
        int rises;
        rises = 0;
        reset_n = 1'b0;
        slow_clock_in = 1'b1;
        repeat (3) @(negedge main_clock);
        checks++; if (outs !== '0) begin failures++; $display("FAIL reset_outs got=%h exp=0", outs); end
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge main_clock);
            if (rise_pulse) rises++;
        end
        checks++; if (rises != 0) begin failures++; $display("FAIL prime_no_rise got=%0d exp=0", rises); end
        checks++; if (outs !== '0) begin failures++; $display("FAIL prime_outs got=%h exp=0", outs); end
        checks++; if (dut.state_q !== ACQUIRE) begin failures++; $display("FAIL prime_state got=%0d exp=%0d", dut.state_q, ACQUIRE); end
    endtask

    task automatic test_toggle();
        for (int i = 1; i <= 6; i++) begin
            if (i > 1) repeat (16) @(negedge main_clock);
            slow_clock_in = ~slow_clock_in;
            repeat (3) @(negedge main_clock);
            checks++;
            if ((slow_clock_in ? rise_pulse : fall_pulse) !== 1'b1 || (slow_clock_in ? fall_pulse : rise_pulse) !== 1'b0) begin
                failures++; $display("FAIL t2_strobe edge=%0d got rise=%b fall=%b exp level=%b", i, rise_pulse, fall_pulse, slow_clock_in);
            end
            @(negedge main_clock);
            checks++; if ({rise_pulse, fall_pulse} !== 2'b00) begin failures++; $display("FAIL t2_strobe_width edge=%0d got=%b exp=00", i, {rise_pulse, fall_pulse}); end
            if (i == 1) begin
                checks++; if (dut.state_q !== MEASURE || period_valid !== 1'b0) begin failures++; $display("FAIL t2_first_edge got state=%0d valid=%b exp state=1 valid=0", dut.state_q, period_valid); end
            end
            if (i == 2) begin
                checks++; if (half_period !== 8'd20) begin failures++; $display("FAIL t2_half got=%0d exp=20", half_period); end
                checks++; if ({period_valid, in_tolerance} !== 2'b11) begin failures++; $display("FAIL t2_valid_tol got=%b exp=11", {period_valid, in_tolerance}); end
            end
        end
        checks++; if (edge_count !== 16'd6) begin failures++; $display("FAIL t2_edge_count got=%0d exp=6", edge_count); end
    endtask

    task automatic test_tolerance();
        tog_gap(23);
        checks++; if (half_period !== 8'd23) begin failures++; $display("FAIL t3_half23 got=%0d exp=23", half_period); end
        checks++; if ({period_valid, in_tolerance} !== 2'b10) begin failures++; $display("FAIL t3_tol23 got=%b exp=10", {period_valid, in_tolerance}); end
        tog_gap(18);
        checks++; if (half_period !== 8'd18 || in_tolerance !== 1'b1) begin failures++; $display("FAIL t3_tol18 got half=%0d tol=%b exp half=18 tol=1", half_period, in_tolerance); end
        tog_gap(22);
        checks++; if (half_period !== 8'd22 || in_tolerance !== 1'b1) begin failures++; $display("FAIL t3_tol22 got half=%0d tol=%b exp half=22 tol=1", half_period, in_tolerance); end
    endtask

    task automatic test_timeout();
        tog_gap(20);
        checks++; if (half_period !== 8'd20 || dut.state_q !== LOCKED) begin failures++; $display("FAIL t4_lock got half=%0d state=%0d exp half=20 state=2", half_period, dut.state_q); end
        repeat (99) @(negedge main_clock);
        checks++; if (clock_lost !== 1'b0) begin failures++; $display("FAIL t4_lost_early got=%b exp=0", clock_lost); end
        @(negedge main_clock);
        checks++; if (clock_lost !== 1'b1) begin failures++; $display("FAIL t4_lost got=%b exp=1", clock_lost); end
        checks++; if ({period_valid, in_tolerance} !== 2'b00) begin failures++; $display("FAIL t4_lost_valid got=%b exp=00", {period_valid, in_tolerance}); end
        checks++; if (half_period !== 8'd20 || edge_count !== 16'd10) begin failures++; $display("FAIL t4_lost_hold got half=%0d cnt=%0d exp half=20 cnt=10", half_period, edge_count); end
        slow_clock_in = ~slow_clock_in;
        repeat (4) @(negedge main_clock);
        checks++; if (clock_lost !== 1'b0 || dut.state_q !== MEASURE) begin failures++; $display("FAIL t4_recover got lost=%b state=%0d exp lost=0 state=1", clock_lost, dut.state_q); end
        checks++; if (edge_count !== 16'd11 || period_valid !== 1'b0) begin failures++; $display("FAIL t4_recover_cnt got cnt=%0d valid=%b exp cnt=11 valid=0", edge_count, period_valid); end
        tog_gap(20);
        checks++; if ({period_valid, in_tolerance} !== 2'b11 || half_period !== 8'd20) begin failures++; $display("FAIL t4_relock got vt=%b half=%0d exp vt=11 half=20", {period_valid, in_tolerance}, half_period); end
    endtask

    task automatic test_edge_at_timeout();
        tog_gap(100);
        checks++; if (clock_lost !== 1'b0 || dut.state_q !== LOCKED) begin failures++; $display("FAIL t5_no_lost got lost=%b state=%0d exp lost=0 state=2", clock_lost, dut.state_q); end
        checks++; if (half_period !== 8'd100) begin failures++; $display("FAIL t5_half got=%0d exp=100", half_period); end
        checks++; if ({period_valid, in_tolerance} !== 2'b10 || edge_count !== 16'd13) begin failures++; $display("FAIL t5_flags got vt=%b cnt=%0d exp vt=10 cnt=13", {period_valid, in_tolerance}, edge_count); end
    endtask

    task automatic test_reset_mid();
        @(negedge main_clock);
        reset_n = 1'b0;
        repeat (2) @(negedge main_clock);
        reset_n = 1'b1;
        repeat (5) @(negedge main_clock);
        slow_clock_in = ~slow_clock_in;
        repeat (4) @(negedge main_clock);
        for (int i = 0; i < 4; i++) tog_gap(20);
        checks++; if (edge_count !== 16'd5 || dut.state_q !== LOCKED) begin failures++; $display("FAIL t6_pre got cnt=%0d state=%0d exp cnt=5 state=2", edge_count, dut.state_q); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (outs !== '0 || dut.state_q !== ACQUIRE) begin failures++; $display("FAIL t6_async_reset got outs=%h state=%0d exp outs=0 state=0", outs, dut.state_q); end
        @(negedge main_clock);
        reset_n = 1'b1;
        repeat (5) @(negedge main_clock);
        slow_clock_in = ~slow_clock_in;
        repeat (4) @(negedge main_clock);
        checks++; if (dut.state_q !== MEASURE || edge_count !== 16'd1 || period_valid !== 1'b0) begin failures++; $display("FAIL t6_measure got state=%0d cnt=%0d valid=%b exp state=1 cnt=1 valid=0", dut.state_q, edge_count, period_valid); end
        tog_gap(20);
        checks++; if (dut.state_q !== LOCKED || half_period !== 8'd20 || {period_valid, in_tolerance} !== 2'b11) begin failures++; $display("FAIL t6_lock got state=%0d half=%0d vt=%b exp state=2 half=20 vt=11", dut.state_q, half_period, {period_valid, in_tolerance}); end
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_tolerance();
        test_timeout();
        test_edge_at_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
